// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
//   Splits an N-byte header (N supplied per packet on the strip channel) off the
//   front of an AXI-Stream packet, delivers it LSB-aligned on the header channel,
//   and re-packs the remaining payload into MSB-first full beats.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_strip/byte_strip_cnt/ready_strip   per-packet header length N
//   valid_in/data_in/keep_in/last_in/ready_in  input stream (byte 0 in the MSBs)
//   valid_hdr/data_hdr/keep_hdr/ready_hdr      header word, last header byte in [7:0]
//   valid_out/data_out/keep_out/last_out/ready_out  re-aligned payload stream
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    ready_strip,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_BODY  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [BYTE_CNT_WD:0] FULL_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    // keep pattern with cnt ones starting at the MSB
    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [BYTE_CNT_WD:0] cnt);
        logic [DATA_BYTE_WD-1:0] k;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k[DATA_BYTE_WD-1-i] = ((BYTE_CNT_WD + 1)'(i) < cnt);
        end
        return k;
    endfunction

    function automatic logic [BYTE_CNT_WD:0] pop_cnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [BYTE_CNT_WD:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + {{BYTE_CNT_WD{1'b0}}, k[i]};
        end
        return c;
    endfunction

    // byte count -> bit shift amount
    function automatic logic [BYTE_CNT_WD+3:0] sh8(input logic [BYTE_CNT_WD:0] c);
        return {c, 3'b000};
    endfunction

    logic [1:0]              state_q, state_d;
    logic [BYTE_CNT_WD:0]    n_q, n_d;
    logic [DATA_WD-1:0]      res_data_q, res_data_d;
    logic [BYTE_CNT_WD:0]    res_cnt_q, res_cnt_d;
    logic                    valid_hdr_q, valid_hdr_d;
    logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;
    // holds ready_strip low while reset is asserted and for the first cycle after
    logic                    active_q;

    // input data with invalid bytes forced to zero so every shift zero-fills
    logic [DATA_WD-1:0]      keep_bits;
    logic [DATA_WD-1:0]      data_in_m;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_keep_bits
            assign keep_bits[gi*8 +: 8] = {8{keep_in[gi]}};
        end
    endgenerate
    assign data_in_m = data_in & keep_bits;

    logic [BYTE_CNT_WD:0] beat_cnt;
    logic [BYTE_CNT_WD:0] take_cnt;
    logic [BYTE_CNT_WD:0] first_r;
    logic [BYTE_CNT_WD:0] body_r;
    logic [BYTE_CNT_WD:0] strip_legal;
    logic                 hdr_free;
    logic                 out_free;

    assign beat_cnt    = pop_cnt(keep_in);
    assign take_cnt    = (beat_cnt < n_q) ? beat_cnt : n_q;
    assign first_r     = (beat_cnt > n_q) ? (beat_cnt - n_q) : '0;
    assign body_r      = beat_cnt - take_cnt;
    assign strip_legal = (byte_strip_cnt == '0 || byte_strip_cnt > FULL_CNT) ? FULL_CNT
                                                                             : byte_strip_cnt;
    assign hdr_free    = !valid_hdr_q || ready_hdr;
    assign out_free    = !valid_out_q || ready_out;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        res_data_d  = res_data_q;
        res_cnt_d   = res_cnt_q;
        valid_hdr_d = valid_hdr_q;
        data_hdr_d  = data_hdr_q;
        keep_hdr_d  = keep_hdr_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        ready_strip = 1'b0;
        ready_in    = 1'b0;

        // drain first; a load below refills the slot on the same edge
        if (valid_hdr_q && ready_hdr) valid_hdr_d = 1'b0;
        if (valid_out_q && ready_out) valid_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_strip = active_q;
                if (valid_strip && active_q) begin
                    n_d     = strip_legal;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                ready_in = hdr_free;
                if (valid_in && hdr_free) begin
                    valid_hdr_d = 1'b1;
                    data_hdr_d  = data_in_m >> sh8(FULL_CNT - n_q);
                    keep_hdr_d  = keep_in >> (FULL_CNT - n_q);
                    res_data_d  = data_in_m << sh8(n_q);
                    res_cnt_d   = first_r;
                    if (last_in) state_d = (first_r != '0) ? ST_FLUSH : ST_IDLE;
                    else         state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                ready_in = out_free;
                if (valid_in && out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_data_q | (data_in_m >> sh8(res_cnt_q));
                    keep_out_d  = msb_ones(res_cnt_q + take_cnt);
                    last_out_d  = last_in && (body_r == '0);
                    res_data_d  = data_in_m << sh8(take_cnt);
                    res_cnt_d   = body_r;
                    if (last_in) state_d = (body_r != '0) ? ST_FLUSH : ST_IDLE;
                end
            end
            default: begin // ST_FLUSH
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_data_q;
                    keep_out_d  = msb_ones(res_cnt_q);
                    last_out_d  = 1'b1;
                    res_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
            valid_hdr_q <= 1'b0;
            data_hdr_q  <= '0;
            keep_hdr_q  <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            res_data_q  <= res_data_d;
            res_cnt_q   <= res_cnt_d;
            valid_hdr_q <= valid_hdr_d;
            data_hdr_q  <= data_hdr_d;
            keep_hdr_q  <= keep_hdr_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            active_q    <= 1'b1;
        end
    end

    assign valid_hdr = valid_hdr_q;
    assign data_hdr  = data_hdr_q;
    assign keep_hdr  = keep_hdr_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header: fixed vectors with hand-computed
// results, a backpressure soak with N=2, and a mid-packet reset.
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_strip;
    logic [2:0]  byte_strip_cnt;
    logic        ready_strip;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_hdr;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;
    logic        ready_hdr;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;

    axi_stream_strip_header dut (
        .clk(clk), .rst_n(rst_n),
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- output monitors (sampled on the falling edge) ----------------
    logic [31:0] o_data[$];
    logic [3:0]  o_keep[$];
    logic        o_last[$];
    int          o_cyc[$];
    logic [7:0]  o_bytes[$];
    logic [31:0] h_data[$];
    logic [3:0]  h_keep[$];

    logic        stall_o = 1'b0, stall_h = 1'b0;
    logic [31:0] prev_od, prev_hd;
    logic [3:0]  prev_ok, prev_hk;
    logic        prev_ol;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_o) begin
                check("out_stable_v", {31'd0, valid_out}, 32'd1);
                check("out_stable_d", data_out, prev_od);
                check("out_stable_k", {28'd0, keep_out}, {28'd0, prev_ok});
                check("out_stable_l", {31'd0, last_out}, {31'd0, prev_ol});
            end
            if (stall_h) begin
                check("hdr_stable_v", {31'd0, valid_hdr}, 32'd1);
                check("hdr_stable_d", data_hdr, prev_hd);
                check("hdr_stable_k", {28'd0, keep_hdr}, {28'd0, prev_hk});
            end
            if (valid_out && ready_out) begin
                o_data.push_back(data_out);
                o_keep.push_back(keep_out);
                o_last.push_back(last_out);
                o_cyc.push_back(cyc);
                for (int k = 0; k < 4; k++)
                    if (keep_out[3-k]) o_bytes.push_back(data_out[31-8*k -: 8]);
            end
            if (valid_hdr && ready_hdr) begin
                h_data.push_back(data_hdr);
                h_keep.push_back(keep_hdr);
            end
            stall_o <= valid_out && !ready_out;
            stall_h <= valid_hdr && !ready_hdr;
            prev_od <= data_out; prev_ok <= keep_out; prev_ol <= last_out;
            prev_hd <= data_hdr; prev_hk <= keep_hdr;
        end else begin
            stall_o <= 1'b0;
            stall_h <= 1'b0;
        end
    end

    // ---------------- driver tasks (return at posedge + 1) ----------------
    task automatic do_strip(input logic [2:0] n);
        logic got = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = n;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (ready_strip) begin got = 1'b1; break; end
        end
        check("strip_handshake", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic got = 1'b0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ready_in) begin got = 1'b1; break; end
        end
        check("beat_handshake", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 300; i++) begin
            if (o_data.size() >= n) break;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    logic [7:0] pkt[$];
    logic [7:0] exp_bytes[$];

    task automatic send_pkt();
        int idx = 0;
        while (idx < pkt.size()) begin
            logic [31:0] d = '0;
            logic [3:0]  k = '0;
            for (int b = 0; b < 4; b++) begin
                if (idx + b < pkt.size()) begin
                    d[31-8*b -: 8] = pkt[idx+b];
                    k[3-b] = 1'b1;
                end
            end
            send_beat(d, k, (idx + 4 >= pkt.size()));
            idx += 4;
        end
    endtask

    int ob, hb, n_pkts, n_pay_pkts, n_last, t0;
    logic t5_done;
    logic bad;

    initial begin
        rst_n = 1'b0; valid_strip = 1'b0; byte_strip_cnt = '0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_hdr = 1'b1; ready_out = 1'b1;
        #12;
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_valid_hdr", {31'd0, valid_hdr}, 32'd0);
        check("rst_ready_strip", {31'd0, ready_strip}, 32'd0);
        check("rst_ready_in", {31'd0, ready_in}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_keep_out", {28'd0, keep_out}, 32'd0);
        check("rst_last_out", {31'd0, last_out}, 32'd0);
        check("rst_data_hdr", data_hdr, 32'd0);
        check("rst_keep_hdr", {28'd0, keep_hdr}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset checked");

        // T1: N=1, 3 full beats
        ob = o_data.size(); hb = h_data.size();
        do_strip(3'd1);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hF, 1'b0);
        send_beat(32'h99AABBCC, 4'hF, 1'b1);
        wait_out(ob + 3);
        check("t1_nbeats", 32'(o_data.size() - ob), 32'd3);
        check("t1_hdr_d", h_data[hb], 32'h00000011);
        check("t1_hdr_k", {28'd0, h_keep[hb]}, 32'h1);
        check("t1_b0_d", o_data[ob], 32'h22334455);
        check("t1_b0_kl", {27'd0, o_keep[ob], o_last[ob]}, {27'd0, 4'hF, 1'b0});
        check("t1_b1_d", o_data[ob+1], 32'h66778899);
        check("t1_b1_kl", {27'd0, o_keep[ob+1], o_last[ob+1]}, {27'd0, 4'hF, 1'b0});
        check("t1_b2_d", o_data[ob+2], 32'hAABBCC00);
        check("t1_b2_kl", {27'd0, o_keep[ob+2], o_last[ob+2]}, {27'd0, 4'hE, 1'b1});
        $display("T1 N=1 done");

        // T2: N=4 pass-through, back-to-back payload beats
        ob = o_data.size(); hb = h_data.size();
        do_strip(3'd4);
        send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
        send_beat(32'hB1B2B3B4, 4'hF, 1'b0);
        send_beat(32'hC1C2C3C4, 4'hF, 1'b1);
        wait_out(ob + 2);
        check("t2_nbeats", 32'(o_data.size() - ob), 32'd2);
        check("t2_hdr_d", h_data[hb], 32'hA1A2A3A4);
        check("t2_hdr_k", {28'd0, h_keep[hb]}, 32'hF);
        check("t2_b0_d", o_data[ob], 32'hB1B2B3B4);
        check("t2_b0_kl", {27'd0, o_keep[ob], o_last[ob]}, {27'd0, 4'hF, 1'b0});
        check("t2_b1_d", o_data[ob+1], 32'hC1C2C3C4);
        check("t2_b1_kl", {27'd0, o_keep[ob+1], o_last[ob+1]}, {27'd0, 4'hF, 1'b1});
        check("t2_rate", 32'(o_cyc[ob+1] - o_cyc[ob]), 32'd1);
        $display("T2 N=4 done");

        // T3: N=3 single beat, remainder flushed
        ob = o_data.size(); hb = h_data.size();
        do_strip(3'd3);
        send_beat(32'h11223344, 4'hF, 1'b1);
        wait_out(ob + 1);
        check("t3_nbeats", 32'(o_data.size() - ob), 32'd1);
        check("t3_hdr_d", h_data[hb], 32'h00112233);
        check("t3_hdr_k", {28'd0, h_keep[hb]}, 32'h7);
        check("t3_b0_d", o_data[ob], 32'h44000000);
        check("t3_b0_kl", {27'd0, o_keep[ob], o_last[ob]}, {27'd0, 4'h8, 1'b1});
        $display("T3 N=3 done");

        // T4: N=2, 2-byte packet -> header only
        ob = o_data.size(); hb = h_data.size();
        do_strip(3'd2);
        send_beat(32'hAABB0000, 4'hC, 1'b1);
        @(negedge clk);
        check("t4_idle_next", {31'd0, ready_strip}, 32'd1);
        repeat (5) @(negedge clk);
        check("t4_no_payload", 32'(o_data.size() - ob), 32'd0);
        check("t4_nhdr", 32'(h_data.size() - hb), 32'd1);
        check("t4_hdr_d", h_data[hb], 32'h0000AABB);
        check("t4_hdr_k", {28'd0, h_keep[hb]}, 32'h3);
        @(posedge clk); #1;
        $display("T4 header-only done");

        // T5: N=2 random packets under random backpressure
        o_bytes.delete(); exp_bytes.delete();
        ob = o_data.size(); hb = h_data.size();
        n_pkts = 0; n_pay_pkts = 0; t5_done = 1'b0; t0 = cyc;
        fork
            begin
                for (int g = 0; g < 5000 && !t5_done; g++) begin
                    ready_out = 1'($urandom_range(0, 1));
                    ready_hdr = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                ready_out = 1'b1; ready_hdr = 1'b1;
            end
            begin
                while (cyc - t0 < 200) begin
                    int len = $urandom_range(2, 12);
                    pkt.delete();
                    for (int b = 0; b < len; b++) pkt.push_back(8'($urandom));
                    for (int b = 2; b < len; b++) exp_bytes.push_back(pkt[b]);
                    do_strip(3'd2);
                    send_pkt();
                    n_pkts++;
                    if (len > 2) n_pay_pkts++;
                end
                t5_done = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        check("t5_nbytes", 32'(o_bytes.size()), 32'(exp_bytes.size()));
        bad = 1'b0;
        for (int b = 0; b < exp_bytes.size() && b < o_bytes.size(); b++)
            if (o_bytes[b] !== exp_bytes[b]) bad = 1'b1;
        check("t5_bytes_match", {31'd0, bad}, 32'd0);
        n_last = 0;
        for (int b = ob; b < o_last.size(); b++) if (o_last[b]) n_last++;
        check("t5_nlast", 32'(n_last), 32'(n_pay_pkts));
        check("t5_nhdr", 32'(h_data.size() - hb), 32'(n_pkts));
        @(posedge clk); #1;
        $display("T5 soak done: %0d packets", n_pkts);

        // T6: reset in mid-BODY, then a clean packet
        ready_out = 1'b1; ready_hdr = 1'b1;
        do_strip(3'd2);
        send_beat(32'h0A0B0C0D, 4'hF, 1'b0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        check("t6_mid_body", {31'd0, valid_out}, 32'd1);
        #2;
        rst_n = 1'b0; valid_in = 1'b0;
        #1;
        check("t6_valid_out", {31'd0, valid_out}, 32'd0);
        check("t6_data_out", data_out, 32'd0);
        check("t6_keep_last", {27'd0, keep_out, last_out}, 32'd0);
        check("t6_valid_hdr", {31'd0, valid_hdr}, 32'd0);
        check("t6_hdr_dk", data_hdr | {28'd0, keep_hdr}, 32'd0);
        check("t6_readys", {30'd0, ready_in, ready_strip}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ob = o_data.size(); hb = h_data.size();
        do_strip(3'd2);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hF, 1'b1);
        wait_out(ob + 2);
        check("t6_nbeats", 32'(o_data.size() - ob), 32'd2);
        check("t6_hdr_d", h_data[hb], 32'h00001122);
        check("t6_hdr_k", {28'd0, h_keep[hb]}, 32'h3);
        check("t6_b0_d", o_data[ob], 32'h33445566);
        check("t6_b0_kl", {27'd0, o_keep[ob], o_last[ob]}, {27'd0, 4'hF, 1'b0});
        check("t6_b1_d", o_data[ob+1], 32'h77880000);
        check("t6_b1_kl", {27'd0, o_keep[ob+1], o_last[ob+1]}, {27'd0, 4'hC, 1'b1});
        $display("T6 reset recovery done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
